// File: rtl/msg_feeder_pkg.sv
`default_nettype none
// msg_feeder_pkg: state encoding, byte width and bitstream-length helper for msg_bit_feeder.
package msg_feeder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Number of bits in the serial stream: payload plus optional length header.
  function automatic logic [63:0] total_bits(input logic [63:0] len_bytes,
                                             input int          len_w,
                                             input bit          hdr_en);
    logic [63:0] hdr_bits;
    hdr_bits = hdr_en ? 64'(len_w) : 64'd0;
    return (len_bytes * 64'(BYTE_W)) + hdr_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_bit_buffer.sv
`default_nettype none
// msg_bit_buffer: bit FIFO with occupancy; bit 0 is the oldest bit. Pushes are
// MSB-first from a right-aligned field, pops take up to POP_W bits with zero fill.
module msg_bit_buffer #(
  parameter int DEPTH  = 9,
  parameter int PUSH_W = 8,
  parameter int POP_W  = 1,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PLW   = $clog2(PUSH_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [PUSH_W-1:0] push_data,
  input  logic [PLW-1:0]    push_len,
  input  logic              pop,
  input  logic [CW-1:0]     pop_n,
  output logic [POP_W-1:0]  pop_data,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     count_nxt
);

  logic [DEPTH-1:0]  bits, bits_nxt, shifted, ins;
  logic [PUSH_W-1:0] rev, rev_sh;
  logic [CW-1:0]     cnt, base;
  logic [PLW-1:0]    shamt;

  always_comb begin
    // Reverse the field so its MSB lands at the lowest free position.
    for (int k = 0; k < PUSH_W; k++) rev[k] = push_data[PUSH_W-1-k];
    shamt   = PLW'(PUSH_W) - push_len;
    rev_sh  = rev >> shamt;
    ins     = {{(DEPTH-PUSH_W){1'b0}}, rev_sh};
    // Pop from the pre-push contents; the pushed bits follow what remains.
    shifted = pop ? (bits >> pop_n) : bits;
    base    = pop ? (cnt - pop_n) : cnt;
    bits_nxt  = shifted;
    count_nxt = base;
    if (push) begin
      bits_nxt  = shifted | (ins << base);
      count_nxt = base + CW'(push_len);
    end
    if (clr) begin
      bits_nxt  = '0;
      count_nxt = '0;
    end
  end

  always_comb begin
    for (int k = 0; k < POP_W; k++) pop_data[k] = (CW'(k) < pop_n) ? bits[k] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bits <= '0;
      cnt  <= '0;
    end else begin
      bits <= bits_nxt;
      cnt  <= count_nxt;
    end
  end

  assign count = cnt;

endmodule
`default_nettype wire

// File: rtl/msg_bit_feeder.sv
`default_nettype none
// msg_bit_feeder: serialises a byte-stream message into FRAME_SIZE-bit chunks, one per frame.
// Define MSG_HEADER_EN to prefix the stream with the LEN_W-bit byte count (MSB-first).
module msg_bit_feeder
  import msg_feeder_pkg::*;
#(
  parameter int FRAME_SIZE = 1,
  parameter int LEN_W      = 16
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_start,
  input  logic [LEN_W-1:0]      in_msg_len,
  input  logic [7:0]            in_byte,
  input  logic                  in_byte_valid,
  output logic                  out_byte_ready,
  input  logic                  in_frame_req,
  output logic [FRAME_SIZE-1:0] out_message,
  output logic                  out_enable,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_underrun
);

`ifdef MSG_HEADER_EN
  localparam bit HDR_EN = 1'b1;
  localparam int PUSH_W = LEN_W + BYTE_W;
`else
  localparam bit HDR_EN = 1'b0;
  localparam int PUSH_W = BYTE_W;
`endif
  localparam int DEPTH = FRAME_SIZE + PUSH_W;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PLW   = $clog2(PUSH_W + 1);
  localparam int BL_W  = LEN_W + 4;

  state_t                state, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      bytes_acc, bytes_d;
  logic [BL_W-1:0]       bits_left, bits_left_d, total;
  logic [CW-1:0]         cnt, cnt_nxt, want;
  logic [FRAME_SIZE-1:0] pop_data;
  logic                  accept, start_ok, pop_ok, frame_live, underrun_evt, ready_d;
  logic                  push;
  logic [PUSH_W-1:0]     push_data;
  logic [PLW-1:0]        push_len;

  assign accept       = out_byte_ready && in_byte_valid;
  assign start_ok     = in_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign total        = BL_W'(total_bits(64'(in_msg_len), LEN_W, HDR_EN));
  assign want         = (bits_left < BL_W'(FRAME_SIZE)) ? bits_left[CW-1:0] : CW'(FRAME_SIZE);
  assign pop_ok       = in_frame_req && (state == ST_RUN) && (cnt >= want);
  assign frame_live   = in_frame_req && (state != ST_IDLE);
  assign underrun_evt = in_frame_req && ((state == ST_RUN) || (state == ST_HDR)) && !pop_ok;

`ifdef MSG_HEADER_EN
  // The buffer is empty in HDR, so a byte accepted there rides behind the header.
  always_comb begin
    push      = accept;
    push_data = {{LEN_W{1'b0}}, in_byte};
    push_len  = PLW'(BYTE_W);
    if (state == ST_HDR) begin
      push      = 1'b1;
      push_data = accept ? {len_q, in_byte} : {{BYTE_W{1'b0}}, len_q};
      push_len  = accept ? PLW'(LEN_W + BYTE_W) : PLW'(LEN_W);
    end
  end
`else
  assign push      = accept;
  assign push_data = in_byte;
  assign push_len  = PLW'(BYTE_W);
`endif

  msg_bit_buffer #(
    .DEPTH  (DEPTH),
    .PUSH_W (PUSH_W),
    .POP_W  (FRAME_SIZE)
  ) u_buf (
    .clk       (in_clk),
    .rst_n     (in_rst_n),
    .clr       (start_ok),
    .push      (push),
    .push_data (push_data),
    .push_len  (push_len),
    .pop       (pop_ok),
    .pop_n     (want),
    .pop_data  (pop_data),
    .count     (cnt),
    .count_nxt (cnt_nxt)
  );

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) state <= ST_IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (in_start) begin
`ifdef MSG_HEADER_EN
          state_d = ST_HDR;
`else
          state_d = (in_msg_len == '0) ? ST_DONE : ST_RUN;
`endif
        end
      end
      ST_HDR:  state_d = ST_RUN;
      ST_RUN:  if (pop_ok && (bits_left == BL_W'(want))) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_busy = (state == ST_HDR) || (state == ST_RUN);
    out_done = (state == ST_DONE);
  end

  always_comb begin
    len_d       = len_q;
    bytes_d     = bytes_acc;
    bits_left_d = bits_left;
    if (start_ok) begin
      len_d       = in_msg_len;
      bytes_d     = '0;
      bits_left_d = total;
    end else begin
      if (accept) bytes_d     = bytes_acc + LEN_W'(1);
      if (pop_ok) bits_left_d = bits_left - BL_W'(want);
    end
    // Ready is registered, so it is judged against next-cycle occupancy.
    ready_d = ((state_d == ST_HDR) || (state_d == ST_RUN)) &&
              (cnt_nxt <= CW'(FRAME_SIZE)) && (bytes_d < len_d);
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      len_q          <= '0;
      bytes_acc      <= '0;
      bits_left      <= '0;
      out_byte_ready <= 1'b0;
      out_message    <= '0;
      out_enable     <= 1'b0;
      out_underrun   <= 1'b0;
    end else begin
      len_q          <= len_d;
      bytes_acc      <= bytes_d;
      bits_left      <= bits_left_d;
      out_byte_ready <= ready_d;
      out_enable     <= frame_live;
      if (frame_live) out_message <= pop_ok ? pop_data : '0;
      if (start_ok)          out_underrun <= 1'b0;
      else if (underrun_evt) out_underrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_bit_feeder.sv
`default_nettype none
// tb_msg_bit_feeder: drives three feeders (FRAME_SIZE 4, 3, 8) with shared stimulus
// and scoreboards each chunk; default build (MSG_HEADER_EN undefined).
module tb_msg_bit_feeder;

  typedef struct packed {
    logic [7:0] msg;
    logic       done;
    logic       und;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid, frame_req;
  logic [15:0] msg_len;
  logic [7:0]  byte_in;

  logic [3:0] msg4;
  logic [2:0] msg3;
  logic [7:0] msg8;
  logic [7:0] msg_a  [3];
  logic       en_a   [3];
  logic       rdy_a  [3];
  logic       busy_a [3];
  logic       done_a [3];
  logic       und_a  [3];

  exp_t  q [3][$];
  int    n_chk  = 0;
  int    n_fail = 0;
  string nm [3] = '{"fs4", "fs3", "fs8"};

  always #5 clk = ~clk;

  msg_bit_feeder #(.FRAME_SIZE(4), .LEN_W(16)) dut4 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .in_msg_len(msg_len),
    .in_byte(byte_in), .in_byte_valid(byte_valid), .out_byte_ready(rdy_a[0]),
    .in_frame_req(frame_req), .out_message(msg4), .out_enable(en_a[0]),
    .out_busy(busy_a[0]), .out_done(done_a[0]), .out_underrun(und_a[0]));

  msg_bit_feeder #(.FRAME_SIZE(3), .LEN_W(16)) dut3 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .in_msg_len(msg_len),
    .in_byte(byte_in), .in_byte_valid(byte_valid), .out_byte_ready(rdy_a[1]),
    .in_frame_req(frame_req), .out_message(msg3), .out_enable(en_a[1]),
    .out_busy(busy_a[1]), .out_done(done_a[1]), .out_underrun(und_a[1]));

  msg_bit_feeder #(.FRAME_SIZE(8), .LEN_W(16)) dut8 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .in_msg_len(msg_len),
    .in_byte(byte_in), .in_byte_valid(byte_valid), .out_byte_ready(rdy_a[2]),
    .in_frame_req(frame_req), .out_message(msg8), .out_enable(en_a[2]),
    .out_busy(busy_a[2]), .out_done(done_a[2]), .out_underrun(und_a[2]));

  assign msg_a[0] = {4'b0, msg4};
  assign msg_a[1] = {5'b0, msg3};
  assign msg_a[2] = msg8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every out_enable consumes one expected chunk.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (en_a[i]) begin
        if (q[i].size() == 0) begin
          check({nm[i], " unexpected enable"}, 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q[i].pop_front();
          check({nm[i], " message"},  64'(msg_a[i]),  64'(e.msg));
          check({nm[i], " done"},     64'(done_a[i]), 64'(e.done));
          check({nm[i], " underrun"}, 64'(und_a[i]),  64'(e.und));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                       input logic d0, input logic d1, input logic d2, input logic u);
    q[0].push_back(exp_t'({e0, d0, u}));
    q[1].push_back(exp_t'({e1, d1, u}));
    q[2].push_back(exp_t'({e2, d2, u}));
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic start_msg(input logic [15:0] len, input logic [7:0] b, input logic valid,
                           input logic chk_run);
    start      = 1'b1;
    msg_len    = len;
    byte_in    = b;
    byte_valid = valid;
    tick();
    start = 1'b0;
    if (chk_run) begin
      for (int i = 0; i < 3; i++) begin
        check({nm[i], " busy after start"},  64'(busy_a[i]), 64'd1);
        check({nm[i], " ready after start"}, 64'(rdy_a[i]),  64'd1);
        check({nm[i], " done after start"},  64'(done_a[i]), 64'd0);
      end
    end
    repeat (3) tick();
    byte_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({nm[i], " ", tag, " message"},  64'(msg_a[i]),  64'd0);
      check({nm[i], " ", tag, " enable"},   64'(en_a[i]),   64'd0);
      check({nm[i], " ", tag, " ready"},    64'(rdy_a[i]),  64'd0);
      check({nm[i], " ", tag, " busy"},     64'(busy_a[i]), 64'd0);
      check({nm[i], " ", tag, " done"},     64'(done_a[i]), 64'd0);
      check({nm[i], " ", tag, " underrun"}, 64'(und_a[i]),  64'd0);
    end
  endtask

  // 0xA5 streams 1,0,1,0,0,1,0,1; bit 0 of each chunk is the earliest bit.
  task automatic scenario_a5();
    start_msg(16'd1, 8'hA5, 1'b1, 1'b1);
    frame(8'h05, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(8'h0A, 8'h04, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    frame(8'h00, 8'h02, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    frame(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; frame_req = 1'b0;
    msg_len = '0; byte_in = '0;
    repeat (2) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    scenario_a5();

    // 0xFF with zero padding on the short final chunk.
    start_msg(16'd1, 8'hFF, 1'b1, 1'b0);
    frame(8'h0F, 8'h07, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(8'h0F, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    frame(8'h00, 8'h03, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    frame(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    // Underrun before the byte arrives, then 0x3C (stream 0,0,1,1,1,1,0,0).
    start_msg(16'd1, 8'h3C, 1'b0, 1'b0);
    frame(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    byte_valid = 1'b1;
    repeat (2) tick();
    byte_valid = 1'b0;
    tick();
    frame(8'h0C, 8'h04, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(8'h03, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    frame(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset with a byte buffered mid-RUN, then the first scenario again.
    start_msg(16'd1, 8'hA5, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    check_idle_outputs("mid-run reset");
    rst_n = 1'b1;
    tick();
    scenario_a5();

    // Zero-length message completes immediately.
    start   = 1'b1;
    msg_len = 16'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({nm[i], " len0 done"},  64'(done_a[i]), 64'd1);
      check({nm[i], " len0 busy"},  64'(busy_a[i]), 64'd0);
      check({nm[i], " len0 ready"}, 64'(rdy_a[i]),  64'd0);
    end
    frame(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    repeat (2) tick();
    for (int i = 0; i < 3; i++)
      check({nm[i], " pending chunks"}, 64'(q[i].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
